rob_commit_unit: RTL and testbench

//  In-order retirement stage directly downstream of the ROB circular queue.
//  - Inspects the ROB head entry and, when that entry is done, pulses the ROB commit input.
//  - Writes the result to the architectural regfile and clears the rename tag.
//  - Performs stores at retirement and raises a pipeline flush on a mispredicted branch/jump.
//  - Retires at most one instruction per cycle.

---
 rtl/rv32_ooo_pkg.sv | 18 +
 rtl/register.sv | 18 +
 rtl/rob_commit_unit.sv | 121 ++++++++++++
 tb/tb_rob_commit_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ooo_pkg.sv
// Shared types for the out-of-order RV32 core: retirement FSM states and
// architectural register helpers.
package rv32_ooo_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2
  } commit_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hard-wired to zero, so a retirement into it never writes the regfile.
  function automatic logic rf_write_allowed(input logic [4:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/register.sv
// Generic enabled register with synchronous active-low reset.
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement stage: commits the ROB head, writes the regfile, performs
// stores at retirement and raises a one-cycle flush on a mispredicted branch/jump.
module rob_commit_unit
  import rv32_ooo_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rob_empty,
  input  logic             rob_head_ready,
  input  logic [IDX_W-1:0] rob_head_idx,
  input  logic [4:0]       rob_head_rd,
  input  logic [31:0]      rob_head_val,
  input  logic             rob_head_is_st,
  input  logic [31:0]      rob_head_st_addr,
  input  logic [31:0]      rob_head_st_data,
  input  logic [3:0]       rob_head_st_mask,
  input  logic             rob_head_mispred,
  input  logic [31:0]      rob_head_target,
  output logic             rob_commit,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_data,
  output logic [IDX_W-1:0] rf_tag,
  output logic             dmem_req,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_wmask,
  input  logic             dmem_resp,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] retired_cnt
);

  commit_state_t    state;
  logic             head_ok;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_next;

  assign head_ok  = ~rob_empty & rob_head_ready;
  assign cnt_en   = rob_commit;
  assign cnt_next = retired_cnt + CNT_W'(1);

  // Commit and regfile write are combinational so a ready head retires in the
  // cycle it is seen; they are forced low while reset is asserted.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    rob_commit = 1'b0;
    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_data    = '0;
    rf_tag     = '0;
    if (rst) begin
      case (state)
        RUN: begin
          if (head_ok && !rob_head_is_st) begin
            rob_commit = 1'b1;
            rf_we      = rf_write_allowed(rob_head_rd);
            rf_rd      = rob_head_rd;
            rf_data    = rob_head_val;
            rf_tag     = rob_head_idx;
          end
        end
        ST_WAIT: rob_commit = dmem_resp;
        default: rob_commit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      dmem_req    <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wmask  <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          // A store wins over the mispredict flag on the same head entry.
          if (head_ok && rob_head_is_st) begin
            dmem_req   <= 1'b1;
            dmem_addr  <= rob_head_st_addr;
            dmem_wdata <= rob_head_st_data;
            dmem_wmask <= rob_head_st_mask;
            state      <= ST_WAIT;
          end else if (head_ok && rob_head_mispred) begin
            flush       <= 1'b1;
            redirect_pc <= rob_head_target;
            state       <= FLUSH;
          end
        end
        ST_WAIT: begin
          if (dmem_resp) begin
            dmem_req <= 1'b0;
            state    <= RUN;
          end
        end
        FLUSH: begin
          flush       <= 1'b0;
          redirect_pc <= '0;
          state       <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  register #(.W(CNT_W)) u_retired_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .d   (cnt_next),
    .q   (retired_cnt)
  );

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_rob_commit_unit;

  localparam int IDX_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             rob_empty, rob_head_ready, rob_head_is_st, rob_head_mispred;
  logic [IDX_W-1:0] rob_head_idx;
  logic [4:0]       rob_head_rd;
  logic [31:0]      rob_head_val, rob_head_st_addr, rob_head_st_data, rob_head_target;
  logic [3:0]       rob_head_st_mask;
  logic             rob_commit, rf_we, dmem_req, dmem_resp, flush;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_data, dmem_addr, dmem_wdata, redirect_pc;
  logic [IDX_W-1:0] rf_tag;
  logic [3:0]       dmem_wmask;
  logic [CNT_W-1:0] retired_cnt;

  always #5 clk = ~clk;

  rob_commit_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .rob_empty        (rob_empty),
    .rob_head_ready   (rob_head_ready),
    .rob_head_idx     (rob_head_idx),
    .rob_head_rd      (rob_head_rd),
    .rob_head_val     (rob_head_val),
    .rob_head_is_st   (rob_head_is_st),
    .rob_head_st_addr (rob_head_st_addr),
    .rob_head_st_data (rob_head_st_data),
    .rob_head_st_mask (rob_head_st_mask),
    .rob_head_mispred (rob_head_mispred),
    .rob_head_target  (rob_head_target),
    .rob_commit       (rob_commit),
    .rf_we            (rf_we),
    .rf_rd            (rf_rd),
    .rf_data          (rf_data),
    .rf_tag           (rf_tag),
    .dmem_req         (dmem_req),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wmask       (dmem_wmask),
    .dmem_resp        (dmem_resp),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .retired_cnt      (retired_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a store outstanding, a flush due, latched store fields and a retire count.
  logic             m_store_busy = 1'b0;
  logic             m_flush_due  = 1'b0;
  logic [31:0]      m_addr = '0, m_data = '0, m_pc = '0;
  logic [3:0]       m_mask = '0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic             force_cnt = 1'b0;
  logic             e_commit, e_we, m_head_ok;

  always begin : compare
    @(negedge clk);
    #2;
    m_head_ok = !rob_empty && rob_head_ready;
    e_commit  = 1'b0;
    e_we      = 1'b0;
    if (rst) begin
      if (m_flush_due)       e_commit = 1'b0;
      else if (m_store_busy) e_commit = dmem_resp;
      else if (m_head_ok && !rob_head_is_st) begin
        e_commit = 1'b1;
        e_we     = (rob_head_rd != 5'd0);
      end
    end
    check("rob_commit", rob_commit, e_commit);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_rd", rf_rd, rob_head_rd);
      check("rf_data", rf_data, rob_head_val);
      check("rf_tag", rf_tag, rob_head_idx);
    end
    check("dmem_req", dmem_req, m_store_busy);
    if (m_store_busy) begin
      check("dmem_addr", dmem_addr, m_addr);
      check("dmem_wdata", dmem_wdata, m_data);
      check("dmem_wmask", dmem_wmask, m_mask);
    end
    check("flush", flush, m_flush_due);
    if (m_flush_due) check("redirect_pc", redirect_pc, m_pc);
    check("retired_cnt", retired_cnt, m_cnt);

    if (!rst) begin
      m_store_busy = 1'b0;
      m_flush_due  = 1'b0;
      m_cnt        = '0;
    end else begin
      if (force_cnt)     m_cnt = '1;
      else if (e_commit) m_cnt = m_cnt + 1;
      if (m_flush_due) m_flush_due = 1'b0;
      else if (m_store_busy) begin
        if (dmem_resp) m_store_busy = 1'b0;
      end else if (m_head_ok && rob_head_is_st) begin
        m_store_busy = 1'b1;
        m_addr = rob_head_st_addr;
        m_data = rob_head_st_data;
        m_mask = rob_head_st_mask;
      end else if (m_head_ok && rob_head_mispred) begin
        m_flush_due = 1'b1;
        m_pc        = rob_head_target;
      end
    end
  end

  logic [IDX_W-1:0] idx_ctr = '0;

  task automatic set_head(input logic e, input logic r, input logic st, input logic mp,
                          input logic [4:0] rd, input logic [31:0] val, input logic [31:0] tgt);
    rob_empty        = e;
    rob_head_ready   = r;
    rob_head_is_st   = st;
    rob_head_mispred = mp;
    rob_head_rd      = rd;
    rob_head_val     = val;
    rob_head_target  = tgt;
    rob_head_idx     = idx_ctr;
    idx_ctr          = idx_ctr + 1'b1;
  endtask

  task automatic idle();
    set_head(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  int req_cycles;

  initial begin : stimulus
    rst              = 1'b0;
    dmem_resp        = 1'b0;
    rob_head_st_addr = 32'h0;
    rob_head_st_data = 32'h0;
    rob_head_st_mask = 4'h0;
    set_head(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h99, 32'h0);

    // Reset held two cycles with a ready head.
    repeat (2) @(negedge clk);
    #3;
    check("rst_commit", rob_commit, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_cnt", retired_cnt, 0);

    // Three normal heads back to back.
    @(negedge clk); rst = 1'b1; set_head(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h11, 32'h0);
    #3; check("n0_commit", rob_commit, 1); check("n0_we", rf_we, 1); check("n0_data", rf_data, 32'h11);
    @(negedge clk); set_head(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h22, 32'h0);
    #3; check("n1_commit", rob_commit, 1); check("n1_we", rf_we, 0);
    @(negedge clk); set_head(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h33, 32'h0);
    #3; check("n2_commit", rob_commit, 1); check("n2_we", rf_we, 1); check("n2_rd", rf_rd, 7);
    @(negedge clk); idle();
    #3; check("n_cnt", retired_cnt, 3);

    // Store acknowledged in the third cycle of dmem_req.
    @(negedge clk);
    set_head(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    rob_head_st_addr = 32'h100; rob_head_st_data = 32'hDEADBEEF; rob_head_st_mask = 4'hF;
    #3; check("st_nocommit", rob_commit, 0); check("st_req_late", dmem_req, 0);
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dmem_resp = (i == 2);
      #3;
      if (dmem_req) req_cycles++;
      check("st_wait_commit", rob_commit, (i == 2));
      check("st_addr", dmem_addr, 32'h100);
      check("st_data", dmem_wdata, 32'hDEADBEEF);
    end
    @(negedge clk); dmem_resp = 1'b0; idle();
    #3; check("st_req_drop", dmem_req, 0); check("st_req_cycles", req_cycles, 3);
    check("st_cnt", retired_cnt, 4);

    // Mispredict: commit + link write, then one flush cycle.
    @(negedge clk); set_head(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h40, 32'h200);
    #3; check("mp_commit", rob_commit, 1); check("mp_rd", rf_rd, 1); check("mp_data", rf_data, 32'h40);
    check("mp_noflush", flush, 0);
    @(negedge clk);
    #3; check("mp_flush", flush, 1); check("mp_pc", redirect_pc, 32'h200);
    check("mp_flush_nocommit", rob_commit, 0); check("mp_flush_nowe", rf_we, 0);
    @(negedge clk); set_head(1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h5, 32'h0);
    #3; check("mp_run_flush", flush, 0); check("mp_run_commit", rob_commit, 1);

    // Empty ROB dominates ready.
    @(negedge clk); set_head(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h77, 32'h0);
    #3; check("empty_nocommit", rob_commit, 0); check("empty_cnt", retired_cnt, 6);

    // Reset while a store is outstanding.
    @(negedge clk); set_head(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    rob_head_st_addr = 32'h44;
    @(negedge clk);
    #3; check("rst_st_req", dmem_req, 1);
    @(negedge clk); rst = 1'b0;
    #3; check("rst_st_nocommit", rob_commit, 0);
    @(negedge clk); rst = 1'b1; idle();
    #3; check("rst_st_req_drop", dmem_req, 0); check("rst_st_cnt", retired_cnt, 0);

    // Preset the counter to all ones, then one commit wraps it.
    @(negedge clk); idle();
    force_cnt = 1'b1;
    force dut.cnt_en = 1'b1;
    force dut.cnt_next = '1;
    @(posedge clk);
    #1;
    release dut.cnt_en;
    release dut.cnt_next;
    force_cnt = 1'b0;
    @(negedge clk); set_head(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h1, 32'h0);
    #3; check("wrap_preset", retired_cnt, 32'hFFFF_FFFF); check("wrap_commit", rob_commit, 1);
    @(negedge clk); idle();
    #3; check("wrap_zero", retired_cnt, 0);

    // Randomized traffic, checked every cycle by the compare process.
    repeat (3000) begin
      @(negedge clk);
      rst              = ($urandom_range(0, 63) != 0);
      dmem_resp        = ($urandom_range(0, 2) == 0);
      rob_empty        = ($urandom_range(0, 4) == 0);
      rob_head_ready   = ($urandom_range(0, 3) != 0);
      rob_head_is_st   = ($urandom_range(0, 4) == 0);
      rob_head_mispred = ($urandom_range(0, 5) == 0);
      rob_head_idx     = IDX_W'($urandom);
      rob_head_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rob_head_val     = $urandom;
      rob_head_target  = $urandom;
      rob_head_st_addr = $urandom;
      rob_head_st_data = $urandom;
      rob_head_st_mask = 4'($urandom);
    end

    @(negedge clk); idle(); dmem_resp = 1'b0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
